// File: rtl/count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// count_ctrl_pkg
// Shared types and helpers for the step-counter scheduler (count_step_ctrl)
// and its round-robin arbiter (rr_arbiter).
//   state_t    : scheduler FSM encoding (IDLE/ISSUE/SETTLE/GAP)
//   clog2Min1  : $clog2 clamped to at least 1 bit, so that one requester
//                or a zero inter-step gap still gives a legal vector width
// ---------------------------------------------------------------------------
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    function automatic int clog2Min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/count_step_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request found when scanning
// upward from the pointer, wrapping past N-1 back to 0.
// Ports:
//   i_req    [N-1:0]     request vector
//   i_ptr    [IDX_W-1:0] index with the highest priority this cycle
//   o_grant  [N-1:0]     one-hot grant (all zero when nothing requests)
//   o_idx    [IDX_W-1:0] index of the granted requester
//   o_valid              at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import count_ctrl_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2Min1(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan offsets 0..N-1 from the pointer; the first hit wins and later
    // hits are masked by o_valid.
    always_comb begin
        int                 w_pos;
        logic [IDX_W-1:0]   w_idx;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            w_idx = IDX_W'(w_pos);
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/count_step_ctrl.sv
// ---------------------------------------------------------------------------
// count_step_ctrl
// Scheduler for the shared up/down step counter (gain/rate index). Picks one
// requester round-robin, checks the step against the live count, issues a
// single inc/dec pulse, waits one cycle for the counter to settle and then
// holds off further grants for GAP_CYCLES cycles.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req   [N_REQ-1:0]     level requests, held until ack/rej
//   i_dir   [N_REQ-1:0]     per-requester direction, 1 = up
//   i_clr                   one-cycle clear request
//   i_count_in              live counter value
//   o_inc, o_dec            step pulses to the counter
//   o_cnt_rst               one-cycle synchronous clear to the counter
//   o_ack, o_rej [N_REQ-1:0] one-hot accept / refuse, ISSUE cycle only
//   o_busy                  high whenever not IDLE
// ---------------------------------------------------------------------------
module count_step_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int MAX          = 10,
    parameter int MAX_BITWIDTH = 5,
    parameter int N_REQ        = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_dir,
    input  logic                    i_clr,
    input  logic [MAX_BITWIDTH-1:0] i_count_in,
    output logic                    o_inc,
    output logic                    o_dec,
    output logic                    o_cnt_rst,
    output logic [N_REQ-1:0]        o_ack,
    output logic [N_REQ-1:0]        o_rej,
    output logic                    o_busy
);

    localparam int PTR_W = clog2Min1(N_REQ);
    localparam int GAP_W = clog2Min1(GAP_CYCLES + 1);

    localparam logic [PTR_W-1:0]        LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [GAP_W-1:0]        GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [MAX_BITWIDTH-1:0] MAX_VAL  = MAX_BITWIDTH'(MAX);

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant_idx;
    logic [N_REQ-1:0]   r_grant;
    logic               r_dir;
    logic               r_cnt_rst;
    logic [GAP_W-1:0]   r_gap;

    logic [N_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic               w_start;
    logic               w_legal;
    logic               w_in_issue;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // clr wins over any request in the same IDLE cycle.
    assign w_start    = (r_state == ST_IDLE) && !i_clr && w_grant_valid;
    assign w_in_issue = (r_state == ST_ISSUE);

    // Saturation is judged only from the live count and the captured
    // direction, never from the requester's current req/dir.
    assign w_legal = r_dir ? (i_count_in < MAX_VAL) : (i_count_in != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next_state = ST_ISSUE;
            ST_ISSUE:  w_next_state = w_legal ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: w_next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:    if (r_gap <= GAP_W'(1)) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Grant capture, pointer advance, gap countdown and the registered clear
    // pulse. The gap counter leaves GAP on the cycle it reaches zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
            r_dir       <= 1'b0;
            r_cnt_rst   <= 1'b0;
            r_gap       <= '0;
        end else begin
            r_cnt_rst <= (r_state == ST_IDLE) && i_clr;
            if (w_start) begin
                r_grant_idx <= w_grant_idx;
                r_grant     <= w_grant;
                r_dir       <= i_dir[w_grant_idx];
            end
            if (w_in_issue) begin
                r_ptr <= (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + PTR_W'(1);
            end
            if (r_state == ST_SETTLE) begin
                r_gap <= GAP_LOAD;
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    // Step and handshake outputs are decoded from state so an asynchronous
    // reset removes them at once.
    always_comb begin
        o_inc     = w_in_issue && w_legal && r_dir;
        o_dec     = w_in_issue && w_legal && !r_dir;
        o_ack     = (w_in_issue && w_legal)  ? r_grant : '0;
        o_rej     = (w_in_issue && !w_legal) ? r_grant : '0;
        o_busy    = (r_state != ST_IDLE);
        o_cnt_rst = r_cnt_rst;
    end

endmodule
